// File: rtl/wb_group_sequencer.sv
// Vector writeback sequencer: walks a register group, asserting WB_PORTS load enables per beat.
// Define WB_FRAC_LMUL_EN to accept fractional LMUL codes (101/110/111) as single-register writes.
module wb_group_sequencer #(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned WB_PORTS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_sel,
  input  logic [2:0]           req_vlmul,
  input  logic                 wb_stall,
  input  logic                 flush,
  output logic [NUM_VREGS-1:0] wb_reg_load,
  output logic [2:0]           wb_beat,
  output logic                 wb_last,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     base_q, base_d;
  logic [3:0]           grp_q, grp_d;
  logic [2:0]           beat_q, beat_d;
  logic [2:0]           last_q, last_d;
  logic                 err_q, err_d;

  logic [3:0]           req_grp;
  logic [2:0]           req_last;
  logic                 req_legal;
  logic                 accept;
  logic                 on_last;
  logic [IDX_W-1:0]     idx;
  logic [NUM_VREGS-1:0] beat_mask;

  // Request decode: group size, last beat index and legality (reserved code, alignment).
  always_comb begin
    req_grp   = 4'd1 << req_vlmul[1:0];
    req_legal = ~req_vlmul[2];
`ifdef WB_FRAC_LMUL_EN
    if (req_vlmul[2]) begin
      req_grp   = 4'd1;
      req_legal = (req_vlmul[1:0] != 2'b00);
    end
`endif
    if ((req_sel & IDX_W'(req_grp - 4'd1)) != '0) begin
      req_legal = 1'b0;
    end
    req_last = (32'(req_grp) > WB_PORTS) ? 3'(32'(req_grp) / WB_PORTS - 32'd1) : 3'd0;
  end

  assign on_last = (beat_q == last_q);
  assign accept  = req_valid & req_ready;

  // Registers covered by the current beat; index arithmetic wraps at IDX_W bits.
  always_comb begin
    beat_mask = '0;
    idx       = '0;
    for (int unsigned j = 0; j < WB_PORTS; j++) begin
      idx = base_q + IDX_W'(beat_q) * IDX_W'(WB_PORTS) + IDX_W'(j);
      if (j < 32'(grp_q)) begin
        beat_mask[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      grp_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      grp_q   <= grp_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    grp_d   = grp_q;
    beat_d  = beat_q;
    last_d  = last_q;
    err_d   = accept & ~req_legal;
    if (flush) begin
      state_d = StIdle;
      beat_d  = '0;
    end else begin
      if (state_q == StActive && !wb_stall) begin
        if (on_last) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      // An accept in ACTIVE only happens on the final unstalled beat, so it chains cleanly.
      if (accept && req_legal) begin
        state_d = StActive;
        base_d  = req_sel;
        grp_d   = req_grp;
        last_d  = req_last;
        beat_d  = '0;
      end
    end
  end

  always_comb begin
    req_ready   = ~flush & ((state_q == StIdle) | ((state_q == StActive) & on_last & ~wb_stall));
    wb_reg_load = '0;
    wb_beat     = '0;
    wb_last     = 1'b0;
    busy        = 1'b0;
    err         = err_q;
    if (state_q == StActive) begin
      wb_reg_load = (flush || wb_stall) ? '0 : beat_mask;
      wb_beat     = beat_q;
      wb_last     = on_last;
      busy        = 1'b1;
    end
  end

endmodule

// File: doc/wb_group_sequencer.md
Name: wb_group_sequencer

Overview:
Multi-cycle vector writeback sequencer. Accepts a writeback request (destination register, vlmul) and walks the register group, asserting per-register load enables for WB_PORTS registers per beat until the group is written. It sits between the vector execution datapath and the vector register file. It generalises single-cycle group decode to any register count, multi-beat writeback, stall, flush and error reporting.

Parameters:
NUM_VREGS, 32, number of vector registers; power of two, minimum 8
IDX_W, 5, width of the register index; equals log2(NUM_VREGS)
WB_PORTS, 1, registers written per beat; must be 1, 2 or 4

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  writeback request valid
req_ready  output  1  sequencer can accept a request this cycle
req_sel  input  IDX_W  destination base register
req_vlmul  input  3  group size code: 000=1, 001=2, 010=4, 011=8 registers; others reserved
wb_stall  input  1  register file cannot accept a write this cycle
flush  input  1  abort the current sequence
wb_reg_load  output  NUM_VREGS  per-register load enable for this beat
wb_beat  output  3  index of the current beat within the group
wb_last  output  1  current beat is the final beat of the group
busy  output  1  sequence in progress
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset: state IDLE, beat counter 0, latched base 0, err 0. All outputs read 0 except req_ready, which reads 1.
- States are IDLE and ACTIVE.
- Group size G = 1 << req_vlmul[1:0].
- Beat count B = max(1, G / WB_PORTS).
- Beat k writes registers base + k*WB_PORTS through base + k*WB_PORTS + min(G, WB_PORTS) - 1.
- Index arithmetic is IDX_W wide. The alignment check prevents wrap past NUM_VREGS-1.
- Accept condition: req_valid && req_ready.
- req_ready = IDLE, or ACTIVE on the last beat with wb_stall=0 and flush=0. This gives back-to-back groups with no bubble.
- Reject conditions:
  - req_vlmul[2]=1 (reserved).
  - req_sel is not a multiple of G.
  - A rejected request is consumed, writes nothing, and gives err=1 the cycle after accept. State stays or goes IDLE.
- A valid accept latches base = req_sel, G and B, clears the beat counter and enters ACTIVE. The first load appears the cycle after accept (latency 1).
- In ACTIVE:
  - wb_reg_load = beat mask & ~wb_stall.
  - wb_beat = counter.
  - wb_last = (counter == B-1).
  - busy = 1.
- Counter advances only when wb_stall=0. When wb_stall=1 all outputs hold except wb_reg_load, which is 0.
- Last beat with no stall: go to IDLE, or straight to a new ACTIVE group if a valid accept happens the same cycle.
- flush=1 has priority over everything:
  - That cycle wb_reg_load=0.
  - Next state IDLE; req_ready=0 in the flush cycle.
  - A request presented during flush is not accepted.
- rst mid-sequence behaves like flush plus clearing err.
- In IDLE: wb_reg_load=0, wb_beat=0, wb_last=0, busy=0.
- When WB_PORTS > G: a single beat with G enables.

Optional Feature:
- Macro: WB_FRAC_LMUL_EN.
- When defined:
  - req_vlmul 101, 110 and 111 (fractional LMUL) are legal.
  - Each is treated as G=1, B=1: one register, any alignment, no err.
  - 100 stays reserved and still raises err.
- When undefined: every code with req_vlmul[2]=1 is rejected with err.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 0 -> req_ready=1, busy=0, wb_reg_load=0, err=0.
2. Single register (WB_PORTS=1): req_sel=5, vlmul=000 -> next cycle wb_reg_load=0x0000_0020, wb_last=1, then IDLE.
3. Group of 8 (WB_PORTS=2): req_sel=8, vlmul=011 -> 4 beats with masks 0x300, 0xC00, 0x3000, 0xC000; wb_beat 0..3; wb_last only on beat 3.
4. Stall mid-group plus back-to-back:
   - Setup: req_sel=4, vlmul=010, WB_PORTS=1, wb_stall=1 on beat 1 for 3 cycles.
   - Required: wb_reg_load=0 and wb_beat=1 held while stalled; the sequence resumes at 0x20.
   - A second request on the last beat starts with no bubble.
5. Misaligned and reserved requests:
   - req_sel=6, vlmul=010 -> err pulse 1 cycle, no loads.
   - vlmul=100 -> err.
   - vlmul=110 -> err without the macro; with WB_FRAC_LMUL_EN, load 0x40 and no err.
6. Flush: req_sel=16, vlmul=011, flush on beat 2 -> wb_reg_load=0 in the flush cycle, IDLE next cycle, no further loads; a request during flush is not accepted.
